seq_detect_ctrl: RTL and testbench

Programmable controller wrapped around a serial bit-pattern detector. It holds the match configuration: pattern, length, overlap mode and match threshold. It sequences run/stop, accepts a serial bit stream via valid/ready, emits a Mealy-style match pulse, counts matches, and raises a sticky interrupt when the threshold is reached. It sits between a configuration master and a serial input source in the serial-stream datapath.

---
 rtl/seq_detect_pkg.sv | 15 +
 rtl/seq_detect_ctrl_if.sv | 36 +++
 rtl/seq_detect_ctrl_match_core.sv | 56 +++++
 rtl/seq_detect_ctrl.sv | 109 ++++++++++
 tb/tb_seq_detect_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the serial pattern-detector controller.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Lengths beyond the physical window are treated as the full window.
  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Configuration, control and serial-stream bundle between a master and the detector controller.
interface seq_detect_ctrl_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(PAT_W) + 1;

  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_threshold;
  logic             start;
  logic             stop;
  logic             clr_irq;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             irq;
  logic             busy;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_threshold,
    output start, stop, clr_irq, in_valid, in_bit,
    input  in_ready, match, match_count, irq, busy
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_threshold,
    input  start, stop, clr_irq, in_valid, in_bit,
    output in_ready, match, match_count, irq, busy
  );

endinterface

// File: rtl/seq_detect_ctrl_match_core.sv
// History shift register, fill counter and window comparator for the serial detector.
module seq_match_core #(
  parameter  int PAT_W = 8,
  localparam int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_bit,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_overlap,
  output logic             o_hit
);

  logic [PAT_W-1:0] r_history;
  logic [LEN_W-1:0] r_fill;
  logic [PAT_W-1:0] w_window;
  logic [PAT_W-1:0] w_mask;
  logic             w_len_ok;
  logic             w_fill_ok;

  assign w_window = {r_history[PAT_W-2:0], i_bit};

  // Only the low len bits of the window take part in the compare.
  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign w_mask[gi] = (LEN_W'(gi) < i_len);
    end
  endgenerate

  assign w_len_ok  = (i_len >= LEN_W'(2));
  assign w_fill_ok = (r_fill >= (i_len - LEN_W'(1)));
  assign o_hit     = i_shift & w_len_ok & w_fill_ok &
                     (((w_window ^ i_pattern) & w_mask) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_history <= '0;
      r_fill    <= '0;
    end else if (i_clr) begin
      r_history <= '0;
      r_fill    <= '0;
    end else if (i_shift) begin
      r_history <= w_window;
      // Non-overlap mode forgets the matched window so none of its bits are reused.
      if (o_hit && !i_overlap)
        r_fill <= '0;
      else if (r_fill != LEN_W'(PAT_W))
        r_fill <= r_fill + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run/stop controller around seq_match_core: config registers, match counter and sticky irq.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter  int PAT_W = 8,
  parameter  int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W) + 1
) (
  input logic              clk,
  input logic              reset,
  seq_detect_ctrl_if.slave bus
);

  state_t           r_state;
  state_t           w_state_next;
  logic [PAT_W-1:0] r_cfg_pattern;
  logic [LEN_W-1:0] r_cfg_len;
  logic             r_cfg_overlap;
  logic [CNT_W-1:0] r_cfg_threshold;
  logic [CNT_W-1:0] r_count;
  logic             r_irq;

  logic [LEN_W-1:0] w_len_eff;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_accept;
  logic             w_hit;
  logic             w_thr_hit;
  logic             w_start_go;

  assign w_len_eff   = LEN_W'(clamp_len(int'(r_cfg_len), PAT_W));
  // stop wins over a simultaneous bit, so that bit never reaches the core.
  assign w_accept    = (r_state == RUN) & bus.in_valid & ~bus.stop;
  assign w_start_go  = bus.start & (r_state != RUN);
  assign w_count_inc = (r_count == '1) ? r_count : r_count + 1'b1;
  assign w_thr_hit   = w_hit & (r_cfg_threshold != '0) & (w_count_inc == r_cfg_threshold);

  seq_match_core #(.PAT_W(PAT_W)) u_core (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_start_go),
    .i_shift   (w_accept),
    .i_bit     (bus.in_bit),
    .i_pattern (r_cfg_pattern),
    .i_len     (w_len_eff),
    .i_overlap (r_cfg_overlap),
    .o_hit     (w_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (bus.start) w_state_next = RUN;
      RUN: begin
        if (bus.stop)       w_state_next = IDLE;
        else if (w_thr_hit) w_state_next = DONE;
      end
      DONE: begin
        if (bus.start)        w_state_next = RUN;
        else if (bus.clr_irq) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    bus.match    = 1'b0;
    if (r_state == RUN) begin
      bus.in_ready = 1'b1;
      bus.busy     = 1'b1;
      bus.match    = w_hit;
    end
  end

  assign bus.match_count = r_count;
  assign bus.irq         = r_irq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cfg_pattern   <= '0;
      r_cfg_len       <= '0;
      r_cfg_overlap   <= 1'b0;
      r_cfg_threshold <= '0;
      r_count         <= '0;
      r_irq           <= 1'b0;
    end else begin
      if (bus.cfg_we && r_state == IDLE) begin
        r_cfg_pattern   <= bus.cfg_pattern;
        r_cfg_len       <= bus.cfg_len;
        r_cfg_overlap   <= bus.cfg_overlap;
        r_cfg_threshold <= bus.cfg_threshold;
      end

      if (w_start_go)  r_count <= '0;
      else if (w_hit)  r_count <= w_count_inc;

      if (w_start_go)                         r_irq <= 1'b0;
      else if (w_thr_hit)                     r_irq <= 1'b1;
      else if (r_state == DONE && bus.clr_irq) r_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: hand-computed match pulses, counts and state flags.
module tb_seq_detect_ctrl;
  localparam int PAT_W = 8;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  seq_detect_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] pat, input logic [3:0] len,
                           input logic ov, input logic [7:0] thr);
    bus.cfg_we        = 1'b1;
    bus.cfg_pattern   = pat;
    bus.cfg_len       = len;
    bus.cfg_overlap   = ov;
    bus.cfg_threshold = thr;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic send(input logic b, input logic exp_m, input string tag);
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    @(negedge clk);
    check(tag, 32'(bus.match), 32'(exp_m));
    $display("%s: bit=%0b ready=%0b match=%0b count=%0d", tag, b, bus.in_ready, bus.match,
             bus.match_count);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // bits/exp hold n entries, first-sent in bit n-1.
  task automatic run_stream(input logic [7:0] bits, input logic [7:0] exp_m,
                            input int n, input string tag);
    for (int i = 0; i < n; i++)
      send(bits[n-1-i], exp_m[n-1-i], $sformatf("%s_b%0d", tag, i + 1));
  endtask

  initial begin
    reset             = 1'b1;
    bus.cfg_we        = 1'b0;
    bus.cfg_pattern   = '0;
    bus.cfg_len       = '0;
    bus.cfg_overlap   = 1'b0;
    bus.cfg_threshold = '0;
    bus.start         = 1'b0;
    bus.stop          = 1'b0;
    bus.clr_irq       = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_bit        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_match", 32'(bus.match), 0);
    check("rst_count", 32'(bus.match_count), 0);
    check("rst_irq", 32'(bus.irq), 0);
    reset = 1'b0;
    tick();

    // Overlapping 0110 on 0,0,1,1,0,1,1,0
    configure(8'b0110, 4'd4, 1'b1, 8'd0);
    pulse_start();
    check("ovl_busy", 32'(bus.busy), 1);
    check("ovl_ready", 32'(bus.in_ready), 1);
    run_stream(8'b00110110, 8'b00001001, 8, "ovl");
    check("ovl_count", 32'(bus.match_count), 2);
    check("ovl_still_run", 32'(bus.busy), 1);
    pulse_stop();
    check("ovl_stopped", 32'(bus.busy), 0);

    // Same stream, non-overlapping
    configure(8'b0110, 4'd4, 1'b0, 8'd0);
    pulse_start();
    check("novl_count_cleared", 32'(bus.match_count), 0);
    run_stream(8'b00110110, 8'b00001000, 8, "novl");
    check("novl_count", 32'(bus.match_count), 1);
    pulse_stop();

    // Threshold of 3 with pattern 11
    configure(8'b11, 4'd2, 1'b1, 8'd3);
    pulse_start();
    run_stream(8'b1111, 8'b0111, 4, "thr");
    check("thr_done_busy", 32'(bus.busy), 0);
    check("thr_done_irq", 32'(bus.irq), 1);
    check("thr_done_ready", 32'(bus.in_ready), 0);
    check("thr_done_count", 32'(bus.match_count), 3);
    send(1'b1, 1'b0, "thr_b5");
    check("thr_b5_count", 32'(bus.match_count), 3);
    bus.clr_irq = 1'b1;
    tick();
    bus.clr_irq = 1'b0;
    check("clr_irq", 32'(bus.irq), 0);
    check("clr_idle_busy", 32'(bus.busy), 0);
    check("clr_idle_ready", 32'(bus.in_ready), 0);
    check("clr_count_held", 32'(bus.match_count), 3);

    // Config write during RUN is ignored; stop beats a matching bit
    configure(8'b11, 4'd2, 1'b1, 8'd0);
    pulse_start();
    configure(8'b00, 4'd2, 1'b1, 8'd0);
    run_stream(8'b1100, 8'b0100, 4, "lock");
    check("lock_count", 32'(bus.match_count), 1);
    send(1'b1, 1'b0, "lock_b5");
    bus.stop = 1'b1;
    send(1'b1, 1'b0, "stop_prio_match");
    bus.stop = 1'b0;
    check("stop_prio_count", 32'(bus.match_count), 1);
    check("stop_prio_idle", 32'(bus.busy), 0);
    check("stop_prio_ready", 32'(bus.in_ready), 0);

    // Length 0 never matches
    configure(8'h00, 4'd0, 1'b1, 8'd0);
    pulse_start();
    run_stream(8'b0000, 8'b0000, 4, "len0");
    check("len0_count", 32'(bus.match_count), 0);
    pulse_stop();

    // Length 15 clamps to 8
    configure(8'hA5, 4'd15, 1'b1, 8'd0);
    pulse_start();
    run_stream(8'b10100101, 8'b00000001, 8, "len15");
    check("len15_count", 32'(bus.match_count), 1);
    pulse_stop();

    // Asynchronous reset between edges after three matches
    configure(8'b11, 4'd2, 1'b1, 8'd0);
    pulse_start();
    run_stream(8'b1111, 8'b0111, 4, "arst");
    check("arst_pre_count", 32'(bus.match_count), 3);
    #2;
    reset = 1'b1;
    #1;
    check("arst_count", 32'(bus.match_count), 0);
    check("arst_irq", 32'(bus.irq), 0);
    check("arst_ready", 32'(bus.in_ready), 0);
    check("arst_busy", 32'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    configure(8'b11, 4'd2, 1'b1, 8'd0);
    pulse_start();
    send(1'b1, 1'b0, "fresh_b1");
    send(1'b1, 1'b1, "fresh_b2");
    check("fresh_count", 32'(bus.match_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
